// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and FSM state type for the writeback stage
// Contents: DATA_W, VEC_LANES, VEC_W, REG_AW, CNT_W (beat-counter width), wb_state_t.
package wb_pkg;
  localparam int DATA_W    = 32;
  localparam int VEC_LANES = 8;
  localparam int VEC_W     = DATA_W * VEC_LANES;
  localparam int REG_AW    = 5;
  localparam int CNT_W     = $clog2(VEC_LANES);

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    COMMIT
  } wb_state_t;
endpackage

// File: rtl/vec_beat_assembler.sv
// rtl/vec_beat_assembler.sv - collects 32-bit load beats into one 256-bit vector word
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear_i         drop the lane store and beat counter
//   beat_valid_i    store beat_data_i into the next lane (lane 0 first)
//   beat_data_i     beat payload
//   word_o          lane store with the current beat already inserted
//   done_o          the beat presented now fills the last lane
module vec_beat_assembler
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              beat_valid_i,
  input  logic [DATA_W-1:0] beat_data_i,
  output logic [VEC_W-1:0]  word_o,
  output logic              done_o
);

  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(VEC_LANES - 1);

  logic [VEC_W-1:0] lanes_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      lanes_q <= '0;
      cnt_q   <= '0;
    end else if (beat_valid_i) begin
      lanes_q[cnt_q*DATA_W +: DATA_W] <= beat_data_i;
      cnt_q                           <= cnt_q + 1'b1;
    end
  end

  // The finishing beat is merged combinationally so the owner can register
  // the complete word on the same edge the last beat arrives.
  always_comb begin
    word_o                          = lanes_q;
    word_o[cnt_q*DATA_W +: DATA_W]  = beat_data_i;
  end

  assign done_o = beat_valid_i && (cnt_q == LAST_LANE);

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - final pipeline stage driving the register-file write interface
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid / in_ready               retiring-instruction handshake from memory stage
//   in_wr_scalar, in_wr_vector        write-enable flags (vector wins if both set)
//   in_sel_mem                        1 = memory source, 0 = ALU source
//   in_rd, in_alu, in_mem_word        destination, ALU result, scalar load data
//   mem_beat_valid, mem_beat_data     vector-load beats
//   WRITEREGISTER_WB, WRITEREGISTERVEC_WB, RD_WB, INPUTDATA   registered write interface
module writeback_stage
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wr_scalar,
  input  logic              in_wr_vector,
  input  logic              in_sel_mem,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [VEC_W-1:0]  in_alu,
  input  logic [DATA_W-1:0] in_mem_word,
  input  logic              mem_beat_valid,
  input  logic [DATA_W-1:0] mem_beat_data,
  output logic              WRITEREGISTER_WB,
  output logic              WRITEREGISTERVEC_WB,
  output logic [31:0]       RD_WB,
  output logic [VEC_W-1:0]  INPUTDATA
);

  wb_state_t         state_q;
  logic [REG_AW-1:0] vec_rd_q;
  logic              ws_q;
  logic              wv_q;
  logic [31:0]       rd_wb_q;
  logic [VEC_W-1:0]  data_q;
  logic              ready_q;

  logic [VEC_W-1:0]  asm_word;
  logic              asm_done;
  logic              xfer;

  // Beats only count while gathering; stray beats elsewhere never reach the lanes.
  vec_beat_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (state_q == COMMIT),
    .beat_valid_i(mem_beat_valid && (state_q == GATHER)),
    .beat_data_i (mem_beat_data),
    .word_o      (asm_word),
    .done_o      (asm_done)
  );

  assign xfer = in_valid && ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_rd_q <= '0;
      ws_q     <= 1'b0;
      wv_q     <= 1'b0;
      rd_wb_q  <= '0;
      data_q   <= '0;
      ready_q  <= 1'b1;
    end else begin
      ws_q <= 1'b0;
      wv_q <= 1'b0;
      case (state_q)
        IDLE, COMMIT: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          if (xfer && in_wr_vector && in_sel_mem) begin
            vec_rd_q <= in_rd;
            state_q  <= GATHER;
            ready_q  <= 1'b0;
          end else if (xfer && in_wr_vector) begin
            wv_q    <= 1'b1;
            rd_wb_q <= {{(32-REG_AW){1'b0}}, in_rd};
            data_q  <= in_alu;
          end else if (xfer && in_wr_scalar) begin
            ws_q    <= 1'b1;
            rd_wb_q <= {{(32-REG_AW){1'b0}}, in_rd};
            data_q  <= {{(VEC_W-DATA_W){1'b0}},
                        (in_sel_mem ? in_mem_word : in_alu[DATA_W-1:0])};
          end
        end
        GATHER: begin
          if (asm_done) begin
            state_q <= COMMIT;
            ready_q <= 1'b1;
            wv_q    <= 1'b1;
            rd_wb_q <= {{(32-REG_AW){1'b0}}, vec_rd_q};
            data_q  <= asm_word;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready            = ready_q;
  assign WRITEREGISTER_WB    = ws_q;
  assign WRITEREGISTERVEC_WB = wv_q;
  assign RD_WB               = rd_wb_q;
  assign INPUTDATA           = data_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - self-checking bench for writeback_stage
module tb_writeback_stage;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_wr_scalar;
  logic         in_wr_vector;
  logic         in_sel_mem;
  logic [4:0]   in_rd;
  logic [255:0] in_alu;
  logic [31:0]  in_mem_word;
  logic         mem_beat_valid;
  logic [31:0]  mem_beat_data;
  logic         WRITEREGISTER_WB;
  logic         WRITEREGISTERVEC_WB;
  logic [31:0]  RD_WB;
  logic [255:0] INPUTDATA;

  int checks = 0;
  int errors = 0;

  // Reference state: the interface holds the last committed write.
  logic [4:0]   last_rd;
  logic [255:0] last_data;

  logic [290:0] obs;
  assign obs = {WRITEREGISTER_WB, WRITEREGISTERVEC_WB, in_ready, RD_WB, INPUTDATA};

  writeback_stage dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_wr_scalar       (in_wr_scalar),
    .in_wr_vector       (in_wr_vector),
    .in_sel_mem         (in_sel_mem),
    .in_rd              (in_rd),
    .in_alu             (in_alu),
    .in_mem_word        (in_mem_word),
    .mem_beat_valid     (mem_beat_valid),
    .mem_beat_data      (mem_beat_data),
    .WRITEREGISTER_WB   (WRITEREGISTER_WB),
    .WRITEREGISTERVEC_WB(WRITEREGISTERVEC_WB),
    .RD_WB              (RD_WB),
    .INPUTDATA          (INPUTDATA)
  );

  always #5 clk = ~clk;

  function automatic logic [290:0] pack(input logic ws, input logic wv, input logic rdy,
                                        input logic [4:0] rd, input logic [255:0] d);
    return {ws, wv, rdy, 27'b0, rd, d};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_inputs();
    in_valid       = 1'b0;
    in_wr_scalar   = 1'b0;
    in_wr_vector   = 1'b0;
    in_sel_mem     = 1'b0;
    in_rd          = '0;
    in_alu         = '0;
    in_mem_word    = '0;
    mem_beat_valid = 1'b0;
    mem_beat_data  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Vector load scenario: accept, 8 beats with optional gaps, commit on the cycle after the last beat.
  task automatic run_vec_load(input logic [4:0] rd, input logic [255:0] beats,
                              input int max_gap, input int forced_gap_lane, input string tag);
    logic [255:0] expv;
    in_valid     = 1'b1;
    in_wr_vector = 1'b1;
    in_sel_mem   = 1'b1;
    in_wr_scalar = 1'($urandom_range(0, 1));
    in_rd        = rd;
    in_alu       = rand256();
    in_mem_word  = $urandom;
    step();
    clear_inputs();
    checks++;
    if (obs[290:288] !== 3'b000) begin
      errors++;
      $display("FAIL %s_accept strobes/ready got %b exp 000", tag, obs[290:288]);
    end
    for (int i = 0; i < 8; i++) begin
      int gaps;
      gaps = (i == forced_gap_lane) ? 1 : $urandom_range(0, max_gap);
      for (int g = 0; g < gaps; g++) begin
        in_valid     = 1'b1;
        in_wr_scalar = 1'b1;
        in_rd        = 5'($urandom);
        in_alu       = rand256();
        step();
        clear_inputs();
        checks++;
        if (obs[290:288] !== 3'b000) begin
          errors++;
          $display("FAIL %s_gap lane %0d strobes/ready got %b exp 000", tag, i, obs[290:288]);
        end
      end
      mem_beat_valid = 1'b1;
      mem_beat_data  = beats[i*32 +: 32];
      step();
      mem_beat_valid = 1'b0;
      if (i < 7) begin
        checks++;
        if (obs[290:288] !== 3'b000) begin
          errors++;
          $display("FAIL %s_beat %0d strobes/ready got %b exp 000", tag, i, obs[290:288]);
        end
      end
    end
    expv = beats;
    checks++;
    if (obs !== pack(1'b0, 1'b1, 1'b1, rd, expv)) begin
      errors++;
      $display("FAIL %s_commit got %h exp %h", tag, obs, pack(1'b0, 1'b1, 1'b1, rd, expv));
    end
    last_rd   = rd;
    last_data = expv;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (obs !== pack(1'b0, 1'b0, 1'b1, 5'd0, 256'd0)) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", obs, pack(1'b0, 1'b0, 1'b1, 5'd0, 256'd0));
    end
    checks++;
    if (dut.u_asm.cnt_q !== 3'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d exp 0", dut.u_asm.cnt_q);
    end
    rst       = 1'b0;
    last_rd   = '0;
    last_data = '0;
  endtask

  task automatic test_scalar_alu();
    logic [255:0] expv;
    in_valid     = 1'b1;
    in_wr_scalar = 1'b1;
    in_sel_mem   = 1'b0;
    in_rd        = 5'd7;
    in_alu       = rand256();
    in_alu[31:0] = 32'hDEADBEEF;
    in_mem_word  = 32'h0BAD0BAD;
    expv         = {224'd0, 32'hDEADBEEF};
    step();
    clear_inputs();
    checks++;
    if (obs !== pack(1'b1, 1'b0, 1'b1, 5'd7, expv)) begin
      errors++;
      $display("FAIL scalar_alu got %h exp %h", obs, pack(1'b1, 1'b0, 1'b1, 5'd7, expv));
    end
    step();
    checks++;
    if (obs !== pack(1'b0, 1'b0, 1'b1, 5'd7, expv)) begin
      errors++;
      $display("FAIL scalar_alu_pulse got %h exp %h", obs, pack(1'b0, 1'b0, 1'b1, 5'd7, expv));
    end
    last_rd   = 5'd7;
    last_data = expv;
  endtask

  task automatic test_back_to_back();
    logic [255:0] a5;
    a5 = {32{8'hA5}};
    in_valid     = 1'b1;
    in_wr_scalar = 1'b1;
    in_sel_mem   = 1'b1;
    in_rd        = 5'd3;
    in_mem_word  = 32'h1234;
    in_alu       = rand256();
    step();
    checks++;
    if (obs !== pack(1'b1, 1'b0, 1'b1, 5'd3, {224'd0, 32'h1234})) begin
      errors++;
      $display("FAIL b2b_scalar_load got %h exp %h", obs, pack(1'b1, 1'b0, 1'b1, 5'd3, {224'd0, 32'h1234}));
    end
    in_wr_scalar = 1'b0;
    in_wr_vector = 1'b1;
    in_sel_mem   = 1'b0;
    in_rd        = 5'd9;
    in_alu       = a5;
    step();
    clear_inputs();
    checks++;
    if (obs !== pack(1'b0, 1'b1, 1'b1, 5'd9, a5)) begin
      errors++;
      $display("FAIL b2b_vector_alu got %h exp %h", obs, pack(1'b0, 1'b1, 1'b1, 5'd9, a5));
    end
    step();
    checks++;
    if (obs !== pack(1'b0, 1'b0, 1'b1, 5'd9, a5)) begin
      errors++;
      $display("FAIL b2b_idle_hold got %h exp %h", obs, pack(1'b0, 1'b0, 1'b1, 5'd9, a5));
    end
    last_rd   = 5'd9;
    last_data = a5;
  endtask

  task automatic test_vector_gaps();
    logic [255:0] beats;
    for (int i = 0; i < 8; i++) beats[i*32 +: 32] = i;
    run_vec_load(5'd12, beats, 0, 4, "vec_gaps");
    step();
    checks++;
    if (obs !== pack(1'b0, 1'b0, 1'b1, 5'd12, beats)) begin
      errors++;
      $display("FAIL vec_gaps_single_commit got %h exp %h", obs, pack(1'b0, 1'b0, 1'b1, 5'd12, beats));
    end
  endtask

  task automatic test_reset_mid_gather();
    logic [255:0] beats;
    in_valid     = 1'b1;
    in_wr_vector = 1'b1;
    in_sel_mem   = 1'b1;
    in_rd        = 5'd20;
    step();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      mem_beat_valid = 1'b1;
      mem_beat_data  = $urandom;
      step();
    end
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (obs !== pack(1'b0, 1'b0, 1'b1, 5'd0, 256'd0)) begin
      errors++;
      $display("FAIL midgather_reset got %h exp %h", obs, pack(1'b0, 1'b0, 1'b1, 5'd0, 256'd0));
    end
    checks++;
    if (dut.u_asm.cnt_q !== 3'd0) begin
      errors++;
      $display("FAIL midgather_reset_cnt got %0d exp 0", dut.u_asm.cnt_q);
    end
    for (int i = 0; i < 8; i++) beats[i*32 +: 32] = 32'h10 + i;
    run_vec_load(5'd21, beats, 0, -1, "midgather_new");
    step();
  endtask

  task automatic test_both_flags();
    logic [255:0] alu;
    alu          = rand256();
    in_valid     = 1'b1;
    in_wr_scalar = 1'b1;
    in_wr_vector = 1'b1;
    in_sel_mem   = 1'b0;
    in_rd        = 5'd5;
    in_alu       = alu;
    in_mem_word  = $urandom;
    step();
    clear_inputs();
    checks++;
    if (obs !== pack(1'b0, 1'b1, 1'b1, 5'd5, alu)) begin
      errors++;
      $display("FAIL both_flags got %h exp %h", obs, pack(1'b0, 1'b1, 1'b1, 5'd5, alu));
    end
    last_rd   = 5'd5;
    last_data = alu;
    step();
  endtask

  task automatic test_stray_beats();
    logic [255:0] beats;
    mem_beat_valid = 1'b1;
    mem_beat_data  = $urandom;
    step();
    in_valid      = 1'b1;
    in_rd         = 5'd17;
    in_alu        = rand256();
    mem_beat_data = $urandom;
    step();
    clear_inputs();
    checks++;
    if (obs !== pack(1'b0, 1'b0, 1'b1, last_rd, last_data)) begin
      errors++;
      $display("FAIL stray_bubble got %h exp %h", obs, pack(1'b0, 1'b0, 1'b1, last_rd, last_data));
    end
    checks++;
    if (dut.u_asm.cnt_q !== 3'd0) begin
      errors++;
      $display("FAIL stray_cnt got %0d exp 0", dut.u_asm.cnt_q);
    end
    beats = rand256();
    run_vec_load(5'd0, beats, 0, -1, "stray_vec");
    // Beat presented during the commit cycle must be ignored.
    mem_beat_valid = 1'b1;
    mem_beat_data  = $urandom;
    step();
    clear_inputs();
    checks++;
    if (dut.u_asm.cnt_q !== 3'd0) begin
      errors++;
      $display("FAIL stray_commit_cnt got %0d exp 0", dut.u_asm.cnt_q);
    end
    beats = rand256();
    run_vec_load(5'd31, beats, 0, -1, "stray_vec2");
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int            op;
      logic [4:0]    rd;
      logic [255:0]  alu;
      logic [31:0]   word;
      logic [290:0]  expo;
      op   = $urandom_range(0, 5);
      rd   = 5'($urandom);
      alu  = rand256();
      word = $urandom;
      if (op == 5) begin
        run_vec_load(rd, rand256(), 2, -1, "rand_vec");
      end else begin
        in_valid       = 1'b1;
        in_rd          = rd;
        in_alu         = alu;
        in_mem_word    = word;
        mem_beat_valid = 1'($urandom_range(0, 1));
        mem_beat_data  = $urandom;
        case (op)
          0: begin in_wr_scalar = 1'b1; in_sel_mem = 1'b0; last_rd = rd; last_data = {224'd0, alu[31:0]}; end
          1: begin in_wr_scalar = 1'b1; in_sel_mem = 1'b1; last_rd = rd; last_data = {224'd0, word}; end
          2: begin in_wr_vector = 1'b1; in_sel_mem = 1'b0; last_rd = rd; last_data = alu; end
          3: begin in_wr_vector = 1'b1; in_wr_scalar = 1'b1; in_sel_mem = 1'b0; last_rd = rd; last_data = alu; end
          default: begin in_valid = 1'($urandom_range(0, 1)); in_sel_mem = 1'($urandom_range(0, 1)); end
        endcase
        expo = pack((op == 0) || (op == 1), (op == 2) || (op == 3), 1'b1, last_rd, last_data);
        step();
        clear_inputs();
        checks++;
        if (obs !== expo) begin
          errors++;
          $display("FAIL random op %0d iter %0d got %h exp %h", op, n, obs, expo);
        end
      end
    end
    step();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_scalar_alu();
    test_back_to_back();
    test_vector_gaps();
    test_reset_mid_gather();
    test_both_flags();
    test_stray_beats();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the interpolation ASIP. It produces the register-file write interface that instruction decode consumes: WRITEREGISTER_WB, WRITEREGISTERVEC_WB, RD_WB and INPUTDATA.
- Results from the memory stage are registered here, the ALU or memory source is selected, and the write strobes are driven.
- Vector loads arrive as 32-bit memory beats; they are assembled into one 256-bit word before commit, and upstream is stalled while that happens.

Parameters:
- DATA_W, 32, scalar word width and memory beat width.
- VEC_LANES, 8, beats per vector; vector width = DATA_W*VEC_LANES = 256.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset: one clock; synchronous, active-high
- in_valid  in  1  memory stage presents a retiring instruction
- in_ready  out  1  stage can accept; low while a vector load is being assembled
- in_wr_scalar  in  1  instruction writes the scalar register file (WriteRegister)
- in_wr_vector  in  1  instruction writes the vector register file (WriteRegisterVec)
- in_sel_mem  in  1  SelWriteData: 1 = memory source, 0 = ALU source
- in_rd  in  REG_AW  destination register
- in_alu  in  256  ALU/vector-unit result; scalar uses [31:0]
- in_mem_word  in  DATA_W  scalar load data, valid with in_valid
- mem_beat_valid  in  1  one vector-load beat present
- mem_beat_data  in  DATA_W  vector-load beat payload
- WRITEREGISTER_WB  out  1  scalar write strobe to decode
- WRITEREGISTERVEC_WB  out  1  vector write strobe to decode
- RD_WB  out  32  destination index, zero-extended from in_rd
- INPUTDATA  out  256  write data; scalar writes use [31:0] with upper bits zero

Behaviour:
- Reset values: both strobes 0, RD_WB 0, INPUTDATA 0, in_ready 1, state IDLE, beat counter 0.
- A transfer occurs when in_valid and in_ready are both 1 on a rising edge.
- FSM states: IDLE, GATHER, COMMIT.
- IDLE, transfer with a single-cycle result (scalar write, or vector write with in_sel_mem=0):
  - Outputs are registered and the strobe is asserted on the next cycle, so latency is 1.
  - The strobe is a one-cycle pulse unless another transfer follows back-to-back.
  - Sustained throughput is 1 instruction per cycle; in_ready stays 1.
- Scalar data select: in_sel_mem=1 → INPUTDATA = {224'b0, in_mem_word}; otherwise {224'b0, in_alu[31:0]}.
- Vector from ALU: INPUTDATA = in_alu.
- IDLE, transfer with in_wr_vector=1 and in_sel_mem=1:
  - Latch in_rd, go to GATHER, drive in_ready=0 and strobes 0.
- GATHER:
  - Each cycle with mem_beat_valid=1 stores mem_beat_data into lane [cnt*32 +: 32], lane 0 first (little-endian lanes), then increments cnt.
  - When the beat with cnt=VEC_LANES-1 is stored, go to COMMIT.
  - Cycles without a beat hold state; there is no timeout.
- COMMIT:
  - WRITEREGISTERVEC_WB=1 for exactly one cycle with the assembled 256-bit INPUTDATA and the latched RD_WB.
  - cnt is cleared and the FSM returns to IDLE; in_ready is 1 in this cycle.
  - A transfer accepted during COMMIT is processed as from IDLE, with its write on the following cycle.
  - Minimum vector-load cost: 1 accept + 8 beats + 1 commit.
- mem_beat_valid in IDLE or COMMIT is ignored and no data is captured.
- Bubbles: transfer with both write flags 0, or in_valid=0 in IDLE → next-cycle strobes 0. RD_WB and INPUTDATA hold their last values.
- in_wr_scalar and in_wr_vector both 1: the vector write wins and the scalar strobe is suppressed. The two strobes are never high together.
- rst asserted in any state, including mid-GATHER: partial vector discarded, no write issued, all reset values restored on the next edge. rst has priority over every other event.
- Writes to register 0 are forwarded unchanged; any zero-register policy belongs to the register files.

Decomposition:
- wb_pkg holds:
  - DATA_W, VEC_LANES, VEC_W, REG_AW constants;
  - the wb_state_t enum {IDLE, GATHER, COMMIT};
  - the beat-counter width $clog2(VEC_LANES).
- One sub-module, vec_beat_assembler, owns the lane shift/insert register, beat counter and done flag. The FSM, source muxing and output registers stay in writeback_stage.

Test Plan:
- Scalar from ALU: in_valid=1, in_wr_scalar=1, in_sel_mem=0, in_rd=7, in_alu[31:0]=0xDEADBEEF → next cycle WRITEREGISTER_WB=1, RD_WB=7, INPUTDATA=0x…0_DEADBEEF, pulse width 1.
- Scalar load then vector ALU back-to-back:
  - cycle 0: rd=3, in_sel_mem=1, in_mem_word=0x1234 → cycle 1: WRITEREGISTER_WB=1, INPUTDATA[31:0]=0x1234;
  - cycle 1: rd=9, vector ALU in_alu=all 0xA5 → cycle 2: WRITEREGISTERVEC_WB=1, INPUTDATA=all 0xA5, WRITEREGISTER_WB=0.
- Vector load with gaps: accept rd=12, then beats 0x0..0x7 with one idle cycle between beats 3 and 4 → in_ready=0 throughout GATHER; a single COMMIT cycle with WRITEREGISTERVEC_WB=1, RD_WB=12, INPUTDATA[i*32+:32]=i.
- Reset mid-GATHER: rst asserted after 4 beats, then a new vector load with beats 0x10..0x17 → no strobe before the new commit; commit data lanes are 0x10..0x17 with no stale lanes.
- Both write flags set with ALU source: rd=5 → only WRITEREGISTERVEC_WB=1, with INPUTDATA=in_alu.
- Stray beats and bubbles: mem_beat_valid=1 in IDLE, plus in_valid=1 with both flags 0 → no strobes, counter stays 0, and the next vector load assembles correctly.
